// File: rtl/ime_sad_min_pkg.sv
// Shared constants and types for the IME SAD minimum search.
// Optional feature macro: IME_MVCOST_EN (adds a lambda-weighted MV cost to every SAD).
package ime_sad_min_pkg;

   // Signed width of each MV component, integer pel.
   localparam int unsigned MV_LEN   = 8;
   // Stored cost width; must cover SAD16X16_LEN+2 when the MV cost is enabled.
   localparam int unsigned COST_LEN = 18;
   // MV-cost multiplier, only consumed when IME_MVCOST_EN is defined.
   localparam int unsigned LAMBDA   = 4;

   localparam int unsigned NUM_PART = 9;

   // Partition slots in the packed result buses.
   localparam int unsigned P8X8_0  = 0;
   localparam int unsigned P8X8_1  = 1;
   localparam int unsigned P8X8_2  = 2;
   localparam int unsigned P8X8_3  = 3;
   localparam int unsigned P16X8_0 = 4;
   localparam int unsigned P16X8_1 = 5;
   localparam int unsigned P8X16_0 = 6;
   localparam int unsigned P8X16_1 = 7;
   localparam int unsigned P16X16  = 8;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSearch = 2'd1,
      StDone   = 2'd2
   } state_e;

endpackage

// File: rtl/ime_min_tracker.sv
// Single compare-and-hold cell: keeps the lowest cost seen since init and its MV.
module ime_min_tracker
   import ime_sad_min_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  init_i,
   input  logic                  upd_i,
   input  logic [COST_LEN-1:0]   cost_i,
   input  logic [2*MV_LEN-1:0]   mv_i,
   output logic [COST_LEN-1:0]   cost_o,
   output logic [2*MV_LEN-1:0]   mv_o
);

   logic [COST_LEN-1:0] cost_q, cost_d;
   logic [2*MV_LEN-1:0] mv_q, mv_d;

   // Init wins over update; strict compare so ties keep the earlier candidate.
   always_comb begin
      cost_d = cost_q;
      mv_d   = mv_q;
      if (init_i) begin
         cost_d = '1;
         mv_d   = '0;
      end else if (upd_i && (cost_i < cost_q)) begin
         cost_d = cost_i;
         mv_d   = mv_i;
      end
   end

   // Cost/MV state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cost_q <= '0;
         mv_q   <= '0;
      end else begin
         cost_q <= cost_d;
         mv_q   <= mv_d;
      end
   end

   assign cost_o = cost_q;
   assign mv_o   = mv_q;

endmodule

// File: rtl/ime_sad_min.sv
// IME search-loop consumer: tracks per-partition minimum cost and MV over one window.
// Optional feature macro: IME_MVCOST_EN (cost = SAD + LAMBDA*(|mvx|+|mvy|), saturated).
module ime_sad_min
   import ime_sad_min_pkg::*;
#(
   parameter int unsigned SAD8X8_LEN   = 14,
   parameter int unsigned SAD16X8_LEN  = 15,
   parameter int unsigned SAD16X16_LEN = 16,
   parameter int unsigned CNT_LEN      = 10
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           start_i,
   input  logic                           valid_i,
   input  logic                           last_i,
   input  logic [MV_LEN-1:0]              mvx_i,
   input  logic [MV_LEN-1:0]              mvy_i,
   input  logic [4*SAD8X8_LEN-1:0]        sad8x8_i,
   input  logic [2*SAD16X8_LEN-1:0]       sad16x8_i,
   input  logic [2*SAD16X8_LEN-1:0]       sad8x16_i,
   input  logic [SAD16X16_LEN-1:0]        sad16x16_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [CNT_LEN-1:0]             cand_cnt_o,
   output logic [NUM_PART*COST_LEN-1:0]   min_cost_o,
   output logic [NUM_PART*2*MV_LEN-1:0]   best_mv_o
);

   state_e              state_q, state_d;
   logic [CNT_LEN-1:0]  cnt_q, cnt_d;
   logic                accept;
   logic [COST_LEN-1:0] sad_ext [NUM_PART];
   logic [COST_LEN-1:0] cost    [NUM_PART];

   // A start in the same cycle drops the candidate.
   assign accept = (state_q == StSearch) && valid_i && !start_i;

   // Next-state logic; start_i re-opens a window from any state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start_i) state_d = StSearch;
         StSearch: begin
            if (start_i) begin
               state_d = StSearch;
            end else if (valid_i && last_i) begin
               state_d = StDone;
            end
         end
         StDone:   state_d = start_i ? StSearch : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign busy_o = (state_q == StSearch);
   assign done_o = (state_q == StDone);

   // Candidate counter, cleared on start and saturating at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (accept && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cand_cnt_o = cnt_q;

   // Zero-extend each partition SAD into the cost width, in result-slot order.
   always_comb begin
      for (int i = 0; i < NUM_PART; i++) sad_ext[i] = '0;
      for (int i = 0; i < 4; i++) begin
         sad_ext[P8X8_0 + i] = COST_LEN'(sad8x8_i[i*SAD8X8_LEN +: SAD8X8_LEN]);
      end
      for (int i = 0; i < 2; i++) begin
         sad_ext[P16X8_0 + i] = COST_LEN'(sad16x8_i[i*SAD16X8_LEN +: SAD16X8_LEN]);
         sad_ext[P8X16_0 + i] = COST_LEN'(sad8x16_i[i*SAD16X8_LEN +: SAD16X8_LEN]);
      end
      sad_ext[P16X16] = COST_LEN'(sad16x16_i);
   end

`ifdef IME_MVCOST_EN
   localparam int unsigned WIDE = COST_LEN + 32;

   logic signed [MV_LEN:0] mvx_ext, mvy_ext;
   logic [MV_LEN:0]        abs_x, abs_y;
   logic [WIDE-1:0]        mv_term;
   logic [WIDE-1:0]        sum_wide [NUM_PART];

   // MV cost is shared by all partitions; the extra bit keeps |-2^(N-1)| exact.
   always_comb begin
      mvx_ext = {mvx_i[MV_LEN-1], mvx_i};
      mvy_ext = {mvy_i[MV_LEN-1], mvy_i};
      abs_x   = mvx_ext[MV_LEN] ? $unsigned(-mvx_ext) : $unsigned(mvx_ext);
      abs_y   = mvy_ext[MV_LEN] ? $unsigned(-mvy_ext) : $unsigned(mvy_ext);
      mv_term = (WIDE'(abs_x) + WIDE'(abs_y)) * WIDE'(LAMBDA);
      for (int i = 0; i < NUM_PART; i++) begin
         sum_wide[i] = WIDE'(sad_ext[i]) + mv_term;
         cost[i]     = (sum_wide[i] > WIDE'({COST_LEN{1'b1}})) ? '1
                                                                : sum_wide[i][COST_LEN-1:0];
      end
   end
`else
   // Cost is the bare SAD.
   always_comb begin
      for (int i = 0; i < NUM_PART; i++) cost[i] = sad_ext[i];
   end
`endif

   for (genvar g = 0; g < NUM_PART; g++) begin : g_trk
      ime_min_tracker u_trk (
         .clk    (clk),
         .rstn   (rstn),
         .init_i (start_i),
         .upd_i  (accept),
         .cost_i (cost[g]),
         .mv_i   ({mvy_i, mvx_i}),
         .cost_o (min_cost_o[g*COST_LEN +: COST_LEN]),
         .mv_o   (best_mv_o[g*2*MV_LEN +: 2*MV_LEN])
      );
   end

endmodule

// File: tb/tb_ime_sad_min.sv
// Directed self-checking bench for ime_sad_min.
module tb_ime_sad_min;

   localparam int S8 = 14;
   localparam int S16 = 15;
   localparam int SMB = 16;
   localparam int CL = 18;
   localparam int ML = 8;
   localparam int CN = 10;

   logic                clk;
   logic                rstn;
   logic                start_i;
   logic                valid_i;
   logic                last_i;
   logic [ML-1:0]       mvx_i;
   logic [ML-1:0]       mvy_i;
   logic [4*S8-1:0]     sad8x8_i;
   logic [2*S16-1:0]    sad16x8_i;
   logic [2*S16-1:0]    sad8x16_i;
   logic [SMB-1:0]      sad16x16_i;
   logic                busy_o;
   logic                done_o;
   logic [CN-1:0]       cand_cnt_o;
   logic [9*CL-1:0]     min_cost_o;
   logic [9*2*ML-1:0]   best_mv_o;

   int n_chk = 0;
   int n_pass = 0;
   int exp_c [9];
   int exp_m [9];

   ime_sad_min u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (start_i),
      .valid_i    (valid_i),
      .last_i     (last_i),
      .mvx_i      (mvx_i),
      .mvy_i      (mvy_i),
      .sad8x8_i   (sad8x8_i),
      .sad16x8_i  (sad16x8_i),
      .sad8x16_i  (sad8x16_i),
      .sad16x16_i (sad16x16_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .cand_cnt_o (cand_cnt_o),
      .min_cost_o (min_cost_o),
      .best_mv_o  (best_mv_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] cost_at(input int i);
      return 32'(min_cost_o[i*CL +: CL]);
   endfunction

   function automatic logic [31:0] mv_at(input int i);
      return 32'(best_mv_o[i*2*ML +: 2*ML]);
   endfunction

   // Compares all nine slots against exp_c / exp_m.
   task automatic check_parts(input string pfx);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("%s_cost%0d", pfx, i), cost_at(i), 32'(exp_c[i]));
         check($sformatf("%s_mv%0d", pfx, i), mv_at(i), 32'(exp_m[i]));
      end
   endtask

   // Inputs change on the falling edge; outputs are read on the next falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic cand_raw(input int x, input int y, input int a0, input int a1, input int a2,
                           input int a3, input int h0, input int h1, input int v0,
                           input int v1, input int w, input logic lst);
      mvx_i      = ML'(x);
      mvy_i      = ML'(y);
      sad8x8_i   = {S8'(a3), S8'(a2), S8'(a1), S8'(a0)};
      sad16x8_i  = {S16'(h1), S16'(h0)};
      sad8x16_i  = {S16'(v1), S16'(v0)};
      sad16x16_i = SMB'(w);
      valid_i    = 1'b1;
      last_i     = lst;
      tick();
      valid_i    = 1'b0;
      last_i     = 1'b0;
   endtask

   // 8x8 blocks in raster order; larger partitions are their true sums.
   task automatic cand_sum(input int x, input int y, input int b0, input int b1, input int b2,
                           input int b3, input logic lst);
      cand_raw(x, y, b0, b1, b2, b3, b0 + b1, b2 + b3, b0 + b2, b1 + b3, b0 + b1 + b2 + b3, lst);
   endtask

   task automatic cand_all(input int x, input int y, input int s, input logic lst);
      cand_raw(x, y, s, s, s, s, s, s, s, s, s, lst);
   endtask

   initial begin
      rstn = 1'b0;
      start_i = 1'b0;
      valid_i = 1'b0;
      last_i = 1'b0;
      mvx_i = '0;
      mvy_i = '0;
      sad8x8_i = '0;
      sad16x8_i = '0;
      sad8x16_i = '0;
      sad16x16_i = '0;
      tick();
      tick();
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done", 32'(done_o), 0);
      check("rst_cnt", 32'(cand_cnt_o), 0);
      check("rst_cost8", cost_at(8), 0);
      check("rst_mv0", mv_at(0), 0);
      rstn = 1'b1;
      tick();

`ifdef IME_MVCOST_EN
      // 100 + 4*(3+2) = 120 loses to 115 at (0,0).
      do_start();
      cand_all(3, -2, 100, 1'b0);
      check("mvc_cost8_a", cost_at(8), 120);
      cand_all(0, 0, 115, 1'b1);
      check("mvc_cost8", cost_at(8), 115);
      check("mvc_mv8", mv_at(8), 32'h0000);
      check("mvc_cnt", 32'(cand_cnt_o), 2);
      check("mvc_done", 32'(done_o), 1);
`else
      // Basic min with a tie on the third candidate.
      do_start();
      check("init_busy", 32'(busy_o), 1);
      check("init_cnt", 32'(cand_cnt_o), 0);
      check("init_cost0", cost_at(0), 32'h3FFFF);
      check("init_mv0", mv_at(0), 0);
      cand_all(5, 5, 100, 1'b0);
      check("basic_done_early", 32'(done_o), 0);
      cand_all(1, 2, 50, 1'b0);
      cand_all(3, 4, 50, 1'b1);
      check("basic_done", 32'(done_o), 1);
      check("basic_busy", 32'(busy_o), 0);
      check("basic_cnt", 32'(cand_cnt_o), 3);
      for (int i = 0; i < 9; i++) begin
         exp_c[i] = 50;
         exp_m[i] = 32'h0201;
      end
      check_parts("basic");
      tick();
      check("basic_done_drop", 32'(done_o), 0);
      check("basic_hold_cost4", cost_at(4), 50);

      // Per-partition independence: A=(1,1), B=(-2,3) -> {mvy,mvx}=0x03FE.
      do_start();
      cand_sum(1, 1, 10, 90, 90, 90, 1'b0);
      cand_sum(-2, 3, 90, 10, 10, 10, 1'b1);
      exp_c = '{10, 10, 10, 10, 100, 20, 100, 20, 120};
      exp_m = '{32'h0101, 32'h03FE, 32'h03FE, 32'h03FE, 32'h0101, 32'h03FE,
                32'h0101, 32'h03FE, 32'h03FE};
      check_parts("indep");
      check("indep_done", 32'(done_o), 1);

      // Start while in DONE: re-initialise and go straight to SEARCH.
      do_start();
      check("dstart_busy", 32'(busy_o), 1);
      check("dstart_cnt", 32'(cand_cnt_o), 0);
      check("dstart_cost8", cost_at(8), 32'h3FFFF);
      check("dstart_mv1", mv_at(1), 0);

      // Restart mid-window with a coincident valid that must be dropped.
      cand_all(1, 1, 10, 1'b0);
      cand_all(2, 2, 20, 1'b0);
      check("rs_cnt_mid", 32'(cand_cnt_o), 2);
      start_i = 1'b1;
      cand_all(4, 4, 5, 1'b0);
      start_i = 1'b0;
      check("rs_cnt_clr", 32'(cand_cnt_o), 0);
      check("rs_cost_clr", cost_at(3), 32'h3FFFF);
      cand_all(7, -1, 200, 1'b1);
      check("rs_cnt", 32'(cand_cnt_o), 1);
      for (int i = 0; i < 9; i++) begin
         exp_c[i] = 200;
         exp_m[i] = 32'hFF07;
      end
      check_parts("rs");

      // Ignored inputs: valid in IDLE, last without valid in SEARCH.
      tick();
      cand_all(9, 9, 1, 1'b1);
      check("ign_idle_busy", 32'(busy_o), 0);
      check("ign_idle_done", 32'(done_o), 0);
      check("ign_idle_cnt", 32'(cand_cnt_o), 1);
      check("ign_idle_cost0", cost_at(0), 200);
      check("ign_idle_mv0", mv_at(0), 32'hFF07);
      do_start();
      cand_all(1, 0, 30, 1'b0);
      last_i = 1'b1;
      tick();
      last_i = 1'b0;
      check("ign_last_busy", 32'(busy_o), 1);
      check("ign_last_done", 32'(done_o), 0);
      check("ign_last_cnt", 32'(cand_cnt_o), 1);
      cand_all(2, 0, 40, 1'b1);
      check("ign_cnt", 32'(cand_cnt_o), 2);
      check("ign_cost8", cost_at(8), 30);
      check("ign_mv8", mv_at(8), 32'h0001);
      tick();

      // Asynchronous reset after five candidates, then a clean window.
      do_start();
      for (int k = 0; k < 5; k++) cand_sum(k, 0, 20 - k, 20, 20, 20, 1'b0);
      #2 rstn = 1'b0;
      #1;
      check("mrst_busy", 32'(busy_o), 0);
      check("mrst_done", 32'(done_o), 0);
      check("mrst_cnt", 32'(cand_cnt_o), 0);
      check("mrst_cost0", cost_at(0), 0);
      check("mrst_cost8", cost_at(8), 0);
      check("mrst_mv0", mv_at(0), 0);
      tick();
      rstn = 1'b1;
      tick();
      check("mrst_idle", 32'(busy_o), 0);
      do_start();
      cand_sum(-1, -1, 7, 8, 9, 10, 1'b0);
      cand_sum(0, 1, 8, 7, 9, 10, 1'b1);
      exp_c = '{7, 7, 9, 10, 15, 19, 16, 17, 34};
      exp_m = '{32'hFFFF, 32'h0100, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF,
                32'hFFFF, 32'h0100, 32'hFFFF};
      check_parts("post");
      check("post_cnt", 32'(cand_cnt_o), 2);
      check("post_done", 32'(done_o), 1);
      tick();

      // Counter saturates at all-ones.
      do_start();
      for (int k = 0; k < 1030; k++) cand_all(0, 0, 1, 1'b0);
      cand_all(0, 0, 1, 1'b1);
      check("sat_cnt", 32'(cand_cnt_o), 32'h3FF);
      check("sat_done", 32'(done_o), 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
